// File: rtl/r2mdc_delay_commutator_if.sv
// Sample-pair stream between R2MDC stages.
//   valid        : d0/d1 carry a valid complex sample pair this cycle
//   d0_re, d0_im : path 0 (upper / butterfly input 0), two's complement
//   d1_re, d1_im : path 1 (lower / butterfly input 1), two's complement
// master drives the stream, slave consumes it.
interface r2mdc_delay_commutator_if #(
    parameter int DATA_W = 16
) ();
    logic              valid;
    logic [DATA_W-1:0] d0_re;
    logic [DATA_W-1:0] d0_im;
    logic [DATA_W-1:0] d1_re;
    logic [DATA_W-1:0] d1_im;

    modport master (output valid, d0_re, d0_im, d1_re, d1_im);
    modport slave  (input  valid, d0_re, d0_im, d1_re, d1_im);
endinterface

// File: rtl/r2mdc_delay_commutator.sv
// Delay-commutator for one R2MDC FFT stage boundary.
// Lower path is pre-delayed by DELAY valid samples, a 2x2 commutator swaps the
// paths every DELAY valid samples, and the upper commutator output is
// post-delayed by DELAY valid samples, yielding butterfly-ready pairs.
// Ports:
//   CLK, RST_N : clock (rising edge), asynchronous active-low reset
//   sync       : frame start; the sample presented this cycle is index 0
//   in_if      : input pair stream (valid, in0 = d0, in1 = d1)
//   out_if     : output pair stream, registered, 1 clk after the input sample
//   phase      : current commutator select (0 = straight, 1 = crossed)
module r2mdc_delay_commutator #(
    parameter int DATA_W = 16,
    parameter int DELAY  = 16
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic                      sync,
    r2mdc_delay_commutator_if.slave   in_if,
    r2mdc_delay_commutator_if.master  out_if,
    output logic                      phase
);
    localparam int PW = $clog2(DELAY);
    localparam int FW = $clog2(DELAY + 1);

    typedef struct packed {
        logic [DATA_W-1:0] re;
        logic [DATA_W-1:0] im;
    } cplx_t;

    // Delay lines; deliberately not reset. out_valid stays low until every
    // slot has been written since the last frame start, so stale contents
    // never appear as valid data.
    cplx_t pre_ram  [DELAY];
    cplx_t post_ram [DELAY];

    logic [PW-1:0] ptr, p, p_nxt;
    logic          sel, s, sel_nxt;
    logic [FW-1:0] fill, f, fill_nxt;
    cplx_t         in0, in1, y1, z0, top, bot;

    assign in0 = '{re: in_if.d0_re, im: in_if.d0_im};
    assign in1 = '{re: in_if.d1_re, im: in_if.d1_im};

    // Effective state for this sample: sync forces a fresh frame so the
    // current sample is processed as index 0 with the commutator straight.
    always_comb begin
        p = ptr;
        s = sel;
        f = fill;
        if (sync) begin
            p = '0;
            s = 1'b0;
            f = '0;
        end
    end

    // Datapath: both RAMs are read before the write at the same slot, which
    // makes each line exactly DELAY valid samples deep.
    always_comb begin
        y1  = pre_ram[p];
        z0  = post_ram[p];
        top = in0;
        bot = y1;
        if (s) begin
            top = y1;
            bot = in0;
        end
    end

    // Pointer wrap toggles the commutator; fill saturates at DELAY.
    always_comb begin
        p_nxt    = p + PW'(1);
        sel_nxt  = s;
        fill_nxt = f;
        if (p == PW'(DELAY - 1)) begin
            p_nxt   = '0;
            sel_nxt = ~s;
        end
        if (f != FW'(DELAY))
            fill_nxt = f + FW'(1);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ptr  <= '0;
            sel  <= 1'b0;
            fill <= '0;
        end else if (in_if.valid) begin
            ptr  <= p_nxt;
            sel  <= sel_nxt;
            fill <= fill_nxt;
        end else if (sync) begin
            // No sample to process: only restart the frame bookkeeping.
            ptr  <= '0;
            sel  <= 1'b0;
            fill <= '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (in_if.valid) begin
            pre_ram[p]  <= in1;
            post_ram[p] <= top;
        end
    end

    // Output registers: data holds across bubbles, valid drops for one clk.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            out_if.valid <= 1'b0;
            out_if.d0_re <= '0;
            out_if.d0_im <= '0;
            out_if.d1_re <= '0;
            out_if.d1_im <= '0;
        end else begin
            out_if.valid <= in_if.valid && (f >= FW'(DELAY));
            if (in_if.valid) begin
                out_if.d0_re <= z0.re;
                out_if.d0_im <= z0.im;
                out_if.d1_re <= bot.re;
                out_if.d1_im <= bot.im;
            end
        end
    end

    assign phase = sel;

endmodule

// File: tb/tb_r2mdc_delay_commutator.sv
// Bench for r2mdc_delay_commutator: a DELAY=4 unit (a) and a DELAY=2 unit (b).
// Expected pairs come from the frame pairing rule (index n since frame start):
// odd block -> (in0[n-D], in0[n]), even block -> (in1[n-2D], in1[n-D]).
module tb_r2mdc_delay_commutator;
    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    logic sync_a = 1'b0, sync_b = 1'b0;
    logic phase_a, phase_b;
    always #5 CLK = ~CLK;

    r2mdc_delay_commutator_if #(.DATA_W(16)) in_a ();
    r2mdc_delay_commutator_if #(.DATA_W(16)) out_a ();
    r2mdc_delay_commutator_if #(.DATA_W(16)) in_b ();
    r2mdc_delay_commutator_if #(.DATA_W(16)) out_b ();

    r2mdc_delay_commutator #(.DATA_W(16), .DELAY(4)) u_a (
        .CLK(CLK), .RST_N(RST_N), .sync(sync_a), .in_if(in_a), .out_if(out_a), .phase(phase_a));
    r2mdc_delay_commutator #(.DATA_W(16), .DELAY(2)) u_b (
        .CLK(CLK), .RST_N(RST_N), .sync(sync_b), .in_if(in_b), .out_if(out_b), .phase(phase_b));

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        v;
        logic        k;     // data fields known
        logic        ph;
        logic [63:0] d;     // {o0re, o0im, o1re, o1im}
    } exp_t;
    exp_t q[$];

    // model state per unit
    int          nidx [2];
    logic        kn   [2];
    logic        ph   [2];
    logic [63:0] lst  [2];
    logic [31:0] h0   [2][512];
    logic [31:0] h1   [2][512];

    typedef struct {
        logic        s;
        logic [15:0] a0, a1;
        logic        ev;
        logic [15:0] e0, e1;
        logic        eph;
    } tv_t;
    tv_t tbl [12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            nidx[u] = 0; kn[u] = 1'b1; ph[u] = 1'b0; lst[u] = '0;
        end
        q.delete();
    endtask

    task automatic model_step(input int u, input logic v, input logic s,
                              input logic [31:0] c0, input logic [31:0] c1, output exp_t e);
        int dd, idx;
        logic vo;
        logic [31:0] o0, o1;
        dd = (u == 0) ? 4 : 2;
        vo = 1'b0;
        if (v) begin
            idx = s ? 0 : nidx[u];
            h0[u][idx] = c0;
            h1[u][idx] = c1;
            if (idx >= dd) begin
                if (((idx / dd) % 2) == 1) begin
                    o0 = h0[u][idx-dd];   o1 = h0[u][idx];
                end else begin
                    o0 = h1[u][idx-2*dd]; o1 = h1[u][idx-dd];
                end
                lst[u] = {o0, o1};
                kn[u]  = 1'b1;
                vo     = 1'b1;
            end else begin
                kn[u] = 1'b0;
            end
            ph[u]   = (((idx + 1) / dd) % 2) == 1;
            nidx[u] = idx + 1;
        end else if (s) begin
            ph[u]   = 1'b0;
            nidx[u] = 0;
        end
        e.v = vo; e.k = kn[u]; e.ph = ph[u]; e.d = lst[u];
    endtask

    task automatic set_in(input int u, input logic v, input logic s,
                          input logic [31:0] c0, input logic [31:0] c1);
        in_a.valid = 1'b0; sync_a = 1'b0;
        in_b.valid = 1'b0; sync_b = 1'b0;
        if (u == 0) begin
            in_a.valid = v; sync_a = s;
            {in_a.d0_re, in_a.d0_im} = c0; {in_a.d1_re, in_a.d1_im} = c1;
        end else begin
            in_b.valid = v; sync_b = s;
            {in_b.d0_re, in_b.d0_im} = c0; {in_b.d1_re, in_b.d1_im} = c1;
        end
    endtask

    task automatic get_out(input int u, output logic v, output logic p, output logic [63:0] d);
        if (u == 0) begin
            v = out_a.valid; p = phase_a;
            d = {out_a.d0_re, out_a.d0_im, out_a.d1_re, out_a.d1_im};
        end else begin
            v = out_b.valid; p = phase_b;
            d = {out_b.d0_re, out_b.d0_im, out_b.d1_re, out_b.d1_im};
        end
    endtask

    // Drive one cycle through the scoreboard and compare 1 clk later.
    task automatic drive(input int u, input logic v, input logic s,
                         input logic [31:0] c0, input logic [31:0] c1, input string nm);
        exp_t e, g;
        logic av, ap;
        logic [63:0] ad;
        set_in(u, v, s, c0, c1);
        model_step(u, v, s, c0, c1, e);
        q.push_back(e);
        @(posedge CLK); #1;
        g = q.pop_front();
        get_out(u, av, ap, ad);
        chk({nm, ".out_valid"}, 32'(av), 32'(g.v));
        chk({nm, ".phase"}, 32'(ap), 32'(g.ph));
        if (g.k) begin
            chk({nm, ".out0"}, ad[63:32], g.d[63:32]);
            chk({nm, ".out1"}, ad[31:0],  g.d[31:0]);
        end
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, ".a_valid"}, 32'(out_a.valid), 32'd0);
        chk({nm, ".a_phase"}, 32'(phase_a), 32'd0);
        chk({nm, ".a_out0"}, {out_a.d0_re, out_a.d0_im}, 32'd0);
        chk({nm, ".a_out1"}, {out_a.d1_re, out_a.d1_im}, 32'd0);
        chk({nm, ".b_valid"}, 32'(out_b.valid), 32'd0);
        chk({nm, ".b_phase"}, 32'(phase_b), 32'd0);
        chk({nm, ".b_out0"}, {out_b.d0_re, out_b.d0_im}, 32'd0);
        chk({nm, ".b_out1"}, {out_b.d1_re, out_b.d1_im}, 32'd0);
    endtask

    function automatic logic [31:0] cx(input logic [15:0] a);
        return {a, ~a};
    endfunction

    initial begin
        logic [31:0] r0, r1;
        logic av, ap;
        logic [63:0] ad;

        for (int i = 0; i < 12; i++) begin
            tbl[i].s   = (i == 0);
            tbl[i].a0  = 16'(i);
            tbl[i].a1  = 16'(100 + i);
            tbl[i].ev  = (i >= 4);
            tbl[i].e0  = (i < 8) ? 16'(i - 4) : 16'(100 + i - 8);
            tbl[i].e1  = (i < 8) ? 16'(i) : 16'(100 + i - 4);
            tbl[i].eph = (i >= 3 && i <= 6) || (i == 11);
        end

        set_in(0, 1'b0, 1'b0, '0, '0);
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        chk_zero("reset");
        RST_N = 1'b1;

        // Priming, table driven on the DELAY=4 unit.
        for (int i = 0; i < 12; i++) begin
            set_in(0, 1'b1, tbl[i].s, cx(tbl[i].a0), cx(tbl[i].a1));
            @(posedge CLK); #1;
            get_out(0, av, ap, ad);
            chk($sformatf("prime%0d.out_valid", i), 32'(av), 32'(tbl[i].ev));
            chk($sformatf("prime%0d.phase", i), 32'(ap), 32'(tbl[i].eph));
            if (tbl[i].ev) begin
                chk($sformatf("prime%0d.out0", i), ad[63:32], cx(tbl[i].e0));
                chk($sformatf("prime%0d.out1", i), ad[31:0],  cx(tbl[i].e1));
            end
        end
        kn[0] = 1'b0;

        // Bubbles on every other cycle.
        for (int i = 0; i < 12; i++) begin
            drive(0, 1'b1, i == 0, cx(16'(i)), cx(16'(100 + i)), "bubble");
            drive(0, 1'b0, 1'b0, cx(16'hDEAD), cx(16'hBEEF), "gap");
        end

        // Commutator wrap over two full periods, then re-sync at sample 6.
        for (int i = 0; i < 16; i++)
            drive(0, 1'b1, i == 0, cx(16'(200 + i)), cx(16'(300 + i)), "wrap");
        for (int i = 0; i < 6; i++)
            drive(0, 1'b1, i == 0, cx(16'(400 + i)), cx(16'(500 + i)), "presync");
        for (int i = 0; i < 12; i++)
            drive(0, 1'b1, i == 0, cx(16'(600 + i)), cx(16'(700 + i)), "resync");

        // Extreme values must pass bit-exact.
        for (int i = 0; i < 12; i++)
            drive(0, 1'b1, i == 0, {16'h8000, 16'(i)}, {16'hFFFF - 16'(i), 16'h7FFF}, "extreme");

        // DELAY=2 unit: sync on an idle cycle, then random data with a bubble.
        drive(1, 1'b0, 1'b1, '0, '0, "d2sync");
        for (int i = 0; i < 10; i++) begin
            r0 = $urandom; r1 = $urandom;
            drive(1, 1'b1, 1'b0, r0, r1, "d2");
            if (i == 5) drive(1, 1'b0, 1'b0, '0, '0, "d2gap");
        end

        // Asynchronous reset mid-stream.
        for (int i = 0; i < 6; i++)
            drive(0, 1'b1, i == 0, cx(16'(800 + i)), cx(16'(900 + i)), "prerst");
        #2 RST_N = 1'b0;
        #1 chk_zero("midrst");
        model_reset();
        @(posedge CLK); #1 RST_N = 1'b1;
        for (int i = 0; i < 10; i++)
            drive(0, 1'b1, 1'b0, cx(16'(1000 + i)), cx(16'(1100 + i)), "postrst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
